// File: rtl/mem_pkg.sv
// Shared types and helpers for the MEM stage.
//   mem_size_t  : funct3 access-size encoding (B/H/W/D signed, BU/HU/WU unsigned)
//   mem_state_t : MEM-stage controller states
//   size_log2   : funct3 -> log2(bytes)
//   misaligned  : address/size alignment test (size D is illegal on a 32-bit datapath)
//   ld_extend   : sign/zero extension of right-aligned load data (64-bit wide, callers truncate)
package mem_pkg;

    typedef enum logic [2:0] {
        SZ_B  = 3'd0,
        SZ_H  = 3'd1,
        SZ_W  = 3'd2,
        SZ_D  = 3'd3,
        SZ_BU = 3'd4,
        SZ_HU = 3'd5,
        SZ_WU = 3'd6
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LD_WAIT    = 2'd1,
        LD_KILL    = 2'd2,
        ECALL_WAIT = 2'd3
    } mem_state_t;

    function automatic logic [1:0] size_log2(input logic [2:0] size);
        case (mem_size_t'(size))
            SZ_B, SZ_BU: return 2'd0;
            SZ_H, SZ_HU: return 2'd1;
            SZ_W, SZ_WU: return 2'd2;
            default:     return 2'd3;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] size,
                                        input logic [2:0] addr_lo,
                                        input logic       xlen32);
        case (size_log2(size))
            2'd0:    return 1'b0;
            2'd1:    return addr_lo[0];
            2'd2:    return |addr_lo[1:0];
            default: return (|addr_lo) || xlen32;
        endcase
    endfunction

    function automatic logic [63:0] ld_extend(input logic [2:0] size, input logic [63:0] data);
        case (mem_size_t'(size))
            SZ_B:    return {{56{data[7]}}, data[7:0]};
            SZ_H:    return {{48{data[15]}}, data[15:0]};
            SZ_W:    return {{32{data[31]}}, data[31:0]};
            SZ_BU:   return {56'd0, data[7:0]};
            SZ_HU:   return {48'd0, data[15:0]};
            SZ_WU:   return {32'd0, data[31:0]};
            default: return data;
        endcase
    endfunction

endpackage

// File: rtl/store_buffer.sv
// Circular store buffer with a CAM lookup for store-to-load forwarding.
//   clk, reset            : clock, synchronous active-high reset (clears pointers)
//   enq, enq_addr/data/size : push a store (ignored when full)
//   deq                   : pop the head entry (ignored when empty)
//   full, empty           : occupancy flags
//   head_addr/data/size   : oldest entry, presented to the D-cache drain path
//   lk_addr, lk_size      : lookup key (dword compare on lk_addr[XLEN-1:3])
//   lk_hit                : some live entry shares the dword
//   lk_exact              : youngest matching entry has identical address and size
//   lk_idx                : slot of the youngest matching entry
//   fwd_idx, fwd_data     : read port used to fetch forwarded store data
module store_buffer #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enq,
    input  logic [XLEN-1:0]          enq_addr,
    input  logic [XLEN-1:0]          enq_data,
    input  logic [1:0]               enq_size,
    input  logic                     deq,
    output logic                     full,
    output logic                     empty,
    output logic [XLEN-1:0]          head_addr,
    output logic [XLEN-1:0]          head_data,
    output logic [1:0]               head_size,
    input  logic [XLEN-1:0]          lk_addr,
    input  logic [1:0]               lk_size,
    output logic                     lk_hit,
    output logic                     lk_exact,
    output logic [$clog2(DEPTH)-1:0] lk_idx,
    input  logic [$clog2(DEPTH)-1:0] fwd_idx,
    output logic [XLEN-1:0]          fwd_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [PW-1:0]   count;
    logic [XLEN-1:0] addr_mem [DEPTH];
    logic [XLEN-1:0] data_mem [DEPTH];
    logic [1:0]      size_mem [DEPTH];
    logic [DEPTH-1:0] match_vec;
    logic [AW-1:0]   scan_idx;

    assign count = wr_ptr_reg - rd_ptr_reg;
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (enq && !full) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (deq && !empty) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    // Payload storage needs no reset: liveness is defined by the pointers.
    always_ff @(posedge clk) begin
        if (enq && !full) begin
            addr_mem[wr_ptr_reg[AW-1:0]] <= enq_addr;
            data_mem[wr_ptr_reg[AW-1:0]] <= enq_data;
            size_mem[wr_ptr_reg[AW-1:0]] <= enq_size;
        end
    end

    assign head_addr = addr_mem[rd_ptr_reg[AW-1:0]];
    assign head_data = data_mem[rd_ptr_reg[AW-1:0]];
    assign head_size = size_mem[rd_ptr_reg[AW-1:0]];

    // Per-slot CAM compare; a slot is live when its age behind the head is below the count.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_cam
            logic [AW-1:0] age;
            assign age = AW'(gi) - rd_ptr_reg[AW-1:0];
            assign match_vec[gi] = ({1'b0, age} < count) &&
                                   (addr_mem[gi][XLEN-1:3] == lk_addr[XLEN-1:3]);
        end
    endgenerate

    // Scan oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        lk_hit   = 1'b0;
        lk_idx   = '0;
        scan_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = rd_ptr_reg[AW-1:0] + AW'(k);
            if (match_vec[scan_idx]) begin
                lk_hit = 1'b1;
                lk_idx = scan_idx;
            end
        end
    end

    assign lk_exact = lk_hit && (addr_mem[lk_idx] == lk_addr) && (size_mem[lk_idx] == lk_size);
    assign fwd_data = data_mem[fwd_idx];

endmodule

// File: rtl/mem_stage_sb.sv
// MEM pipeline stage: store buffer, valid/ready D-cache port, load extension,
// store-to-load forwarding, misalignment detection and flush.
//   clk, reset     : clock, synchronous active-high reset
//   flush          : kill the instruction in MEM (store buffer kept)
//   in_*           : instruction presented by the ALU stage (held while stall=1)
//   stall          : MEM instruction cannot complete this cycle
//   dc_req_*       : D-cache request (single outstanding), dc_size = log2 bytes
//   dc_rsp_valid, dc_rdata : load response, right-aligned
//   wb_*           : registered results to writeback, all zero on a bubble
//   sb_empty       : store buffer empty
module mem_stage_sb
    import mem_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int SB_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_instr,
    input  logic [4:0]      in_rd,
    input  logic            in_regwrite,
    input  logic            in_memread,
    input  logic            in_memwrite,
    input  logic            in_ecall,
    input  logic [2:0]      in_size,
    input  logic [XLEN-1:0] in_addr,
    input  logic [XLEN-1:0] in_wdata,
    output logic            stall,
    output logic            dc_req_valid,
    input  logic            dc_req_ready,
    output logic            dc_req_we,
    output logic [XLEN-1:0] dc_addr,
    output logic [XLEN-1:0] dc_wdata,
    output logic [1:0]      dc_size,
    input  logic            dc_rsp_valid,
    input  logic [XLEN-1:0] dc_rdata,
    output logic            wb_valid,
    output logic [XLEN-1:0] wb_pc,
    output logic [31:0]     wb_instr,
    output logic [4:0]      wb_rd,
    output logic            wb_regwrite,
    output logic            wb_ecall,
    output logic            wb_mem_to_reg,
    output logic [XLEN-1:0] wb_result,
    output logic [XLEN-1:0] wb_ld_result,
    output logic            wb_misalign,
    output logic            sb_empty
);

    localparam int IW = $clog2(SB_DEPTH);

    mem_state_t state_reg, state_next;

    // A load request that was presented but not yet accepted is pinned here so
    // the request stays stable even if the MEM instruction is flushed meanwhile.
    logic            req_lock_reg, req_lock_next;
    logic            req_killed_reg, req_killed_next;
    logic [XLEN-1:0] req_addr_reg;
    logic [1:0]      req_size_reg;
    // Likewise an unaccepted drain keeps ownership of the port.
    logic            drain_lock_reg, drain_lock_next;

    logic            sb_full, sb_hit, sb_exact, sb_deq;
    logic [IW-1:0]   sb_idx;
    logic [XLEN-1:0] sb_head_addr, sb_head_data, sb_fwd_data;
    logic [1:0]      sb_head_size;

    logic            is_misaligned, complete, want_ld, do_enq, misalign_flag;
    logic            ld_go, drain_go;
    logic [XLEN-1:0] ld_value;

    function automatic logic [XLEN-1:0] extend_x(input logic [2:0] size, input logic [XLEN-1:0] raw);
        logic [63:0] wide;
        logic [63:0] ext;
        wide = '0;
        wide[XLEN-1:0] = raw;
        ext = ld_extend(size, wide);
        return ext[XLEN-1:0];
    endfunction

    assign is_misaligned = misaligned(in_size, in_addr[2:0], XLEN == 32);

    store_buffer #(
        .XLEN  (XLEN),
        .DEPTH (SB_DEPTH)
    ) u_sb (
        .clk       (clk),
        .reset     (reset),
        .enq       (do_enq),
        .enq_addr  (in_addr),
        .enq_data  (in_wdata),
        .enq_size  (size_log2(in_size)),
        .deq       (sb_deq),
        .full      (sb_full),
        .empty     (sb_empty),
        .head_addr (sb_head_addr),
        .head_data (sb_head_data),
        .head_size (sb_head_size),
        .lk_addr   (in_addr),
        .lk_size   (size_log2(in_size)),
        .lk_hit    (sb_hit),
        .lk_exact  (sb_exact),
        .lk_idx    (sb_idx),
        .fwd_idx   (sb_idx),
        .fwd_data  (sb_fwd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            req_lock_reg   <= 1'b0;
            req_killed_reg <= 1'b0;
            req_addr_reg   <= '0;
            req_size_reg   <= '0;
            drain_lock_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            req_lock_reg   <= req_lock_next;
            req_killed_reg <= req_killed_next;
            drain_lock_reg <= drain_lock_next;
            if (ld_go && !req_lock_reg) begin
                req_addr_reg <= in_addr;
                req_size_reg <= size_log2(in_size);
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        stall         = 1'b0;
        complete      = 1'b0;
        want_ld       = 1'b0;
        do_enq        = 1'b0;
        misalign_flag = 1'b0;
        ld_value      = '0;

        case (state_reg)
            IDLE: begin
                if (in_valid && !flush) begin
                    if (req_killed_reg) begin
                        // An orphaned load still owns the cache port.
                        stall = 1'b1;
                    end else if ((in_memread || in_memwrite) && is_misaligned) begin
                        complete      = 1'b1;
                        misalign_flag = 1'b1;
                    end else if (in_memwrite) begin
                        // Full stalls even if the head drains this cycle.
                        if (sb_full) begin
                            stall = 1'b1;
                        end else begin
                            do_enq   = 1'b1;
                            complete = 1'b1;
                        end
                    end else if (in_memread) begin
                        if (sb_exact) begin
                            complete = 1'b1;
                            ld_value = extend_x(in_size, sb_fwd_data);
                        end else begin
                            // Partial overlap waits for the buffer to drain past it.
                            stall   = 1'b1;
                            want_ld = !sb_hit;
                        end
                    end else if (in_ecall && !sb_empty) begin
                        stall      = 1'b1;
                        state_next = ECALL_WAIT;
                    end else begin
                        complete = 1'b1;
                    end
                end
            end
            LD_WAIT: begin
                if (flush) begin
                    state_next = dc_rsp_valid ? IDLE : LD_KILL;
                end else if (dc_rsp_valid) begin
                    complete   = 1'b1;
                    ld_value   = extend_x(in_size, dc_rdata);
                    state_next = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            LD_KILL: begin
                stall = in_valid && !flush;
                if (dc_rsp_valid) begin
                    state_next = IDLE;
                end
            end
            ECALL_WAIT: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (sb_empty) begin
                    complete   = 1'b1;
                    state_next = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        // Port arbitration: a new load beats a new drain, but neither preempts a
        // request already presented and waiting for ready.
        ld_go    = (state_reg == IDLE) && !drain_lock_reg && (req_lock_reg || want_ld);
        drain_go = !ld_go && !sb_empty && ((state_reg == IDLE) || (state_reg == ECALL_WAIT));

        dc_req_valid = ld_go || drain_go;
        dc_req_we    = drain_go;
        dc_addr      = '0;
        dc_wdata     = '0;
        dc_size      = '0;
        if (ld_go) begin
            dc_addr = req_lock_reg ? req_addr_reg : in_addr;
            dc_size = req_lock_reg ? req_size_reg : size_log2(in_size);
        end else if (drain_go) begin
            dc_addr  = sb_head_addr;
            dc_wdata = sb_head_data;
            dc_size  = sb_head_size;
        end

        sb_deq          = drain_go && dc_req_ready;
        req_lock_next   = ld_go && !dc_req_ready;
        req_killed_next = ld_go && !dc_req_ready && (req_killed_reg || flush);
        drain_lock_next = drain_go && !dc_req_ready;

        if (ld_go && dc_req_ready) begin
            state_next = (req_killed_reg || flush) ? LD_KILL : LD_WAIT;
        end
    end

    // Writeback register: loads a completed instruction, otherwise a zero bubble.
    always_ff @(posedge clk) begin
        if (reset || !complete) begin
            wb_valid      <= 1'b0;
            wb_pc         <= '0;
            wb_instr      <= '0;
            wb_rd         <= '0;
            wb_regwrite   <= 1'b0;
            wb_ecall      <= 1'b0;
            wb_mem_to_reg <= 1'b0;
            wb_result     <= '0;
            wb_ld_result  <= '0;
            wb_misalign   <= 1'b0;
        end else begin
            wb_valid      <= 1'b1;
            wb_pc         <= in_pc;
            wb_instr      <= in_instr;
            wb_rd         <= in_rd;
            wb_regwrite   <= in_regwrite;
            wb_ecall      <= in_ecall;
            wb_mem_to_reg <= in_memread;
            wb_result     <= in_addr;
            wb_ld_result  <= ld_value;
            wb_misalign   <= misalign_flag;
        end
    end

endmodule

// File: tb/tb_mem_stage_sb.sv
module tb_mem_stage_sb;

    localparam int XLEN     = 64;
    localparam int SB_DEPTH = 4;

    logic            clk = 1'b0;
    logic            reset, flush, in_valid;
    logic [XLEN-1:0] in_pc;
    logic [31:0]     in_instr;
    logic [4:0]      in_rd;
    logic            in_regwrite, in_memread, in_memwrite, in_ecall;
    logic [2:0]      in_size;
    logic [XLEN-1:0] in_addr, in_wdata;
    logic            stall, dc_req_valid, dc_req_ready, dc_req_we;
    logic [XLEN-1:0] dc_addr, dc_wdata;
    logic [1:0]      dc_size;
    logic            dc_rsp_valid;
    logic [XLEN-1:0] dc_rdata;
    logic            wb_valid, wb_regwrite, wb_ecall, wb_mem_to_reg, wb_misalign, sb_empty;
    logic [XLEN-1:0] wb_pc, wb_result, wb_ld_result;
    logic [31:0]     wb_instr;
    logic [4:0]      wb_rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage_sb #(.XLEN(XLEN), .SB_DEPTH(SB_DEPTH)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
        .in_pc(in_pc), .in_instr(in_instr), .in_rd(in_rd), .in_regwrite(in_regwrite),
        .in_memread(in_memread), .in_memwrite(in_memwrite), .in_ecall(in_ecall),
        .in_size(in_size), .in_addr(in_addr), .in_wdata(in_wdata),
        .stall(stall), .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready),
        .dc_req_we(dc_req_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata), .dc_size(dc_size),
        .dc_rsp_valid(dc_rsp_valid), .dc_rdata(dc_rdata),
        .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_instr(wb_instr), .wb_rd(wb_rd),
        .wb_regwrite(wb_regwrite), .wb_ecall(wb_ecall), .wb_mem_to_reg(wb_mem_to_reg),
        .wb_result(wb_result), .wb_ld_result(wb_ld_result), .wb_misalign(wb_misalign),
        .sb_empty(sb_empty)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        in_valid = 0; in_memread = 0; in_memwrite = 0; in_ecall = 0; in_regwrite = 0;
        in_size = 0; in_addr = 0; in_wdata = 0; in_pc = 0; in_instr = 0; in_rd = 0; flush = 0;
    endtask

    task automatic op(input logic is_ld, input logic is_st, input logic is_ec,
                      input logic [2:0] sz, input logic [63:0] addr, input logic [63:0] data);
        in_valid = 1; in_memread = is_ld; in_memwrite = is_st; in_ecall = is_ec;
        in_regwrite = is_ld; in_size = sz; in_addr = addr; in_wdata = data;
        in_rd = 5'd7; in_pc = 64'h8000_0000 + addr; in_instr = 32'h0000_0013;
    endtask

    // Load that misses the store buffer, accepted immediately, response one cycle later.
    task automatic dc_load(input string tag, input logic [2:0] sz, input logic [63:0] addr,
                           input logic [63:0] rdata, input logic [63:0] exp);
        op(1, 0, 0, sz, addr, 0);
        dc_req_ready = 1;
        #1;
        check({tag, " req_valid"}, dc_req_valid, 1);
        check({tag, " req_we"}, dc_req_we, 0);
        check({tag, " req_addr"}, dc_addr, addr);
        check({tag, " stall"}, stall, 1);
        step();
        check({tag, " wb bubble"}, wb_valid, 0);
        dc_rsp_valid = 1; dc_rdata = rdata;
        #1;
        check({tag, " rsp stall"}, stall, 0);
        step();
        dc_rsp_valid = 0;
        idle_in();
        check({tag, " wb_valid"}, wb_valid, 1);
        check({tag, " wb_ld_result"}, wb_ld_result, exp);
        check({tag, " mem_to_reg"}, wb_mem_to_reg, 1);
    endtask

    initial begin
        int n_drain;
        logic got_ld;
        logic done;

        reset = 1; dc_req_ready = 0; dc_rsp_valid = 0; dc_rdata = 0;
        idle_in();
        step(); step();
        check("reset wb_valid", wb_valid, 0);
        check("reset stall", stall, 0);
        check("reset dc_req_valid", dc_req_valid, 0);
        check("reset sb_empty", sb_empty, 1);
        check("reset wb_ld_result", wb_ld_result, 0);
        reset = 0;

        // Non-memory passthrough
        op(0, 0, 0, 0, 64'hABCD, 0); in_regwrite = 1;
        #1;
        check("alu stall", stall, 0);
        step();
        idle_in();
        check("alu wb_valid", wb_valid, 1);
        check("alu wb_result", wb_result, 64'hABCD);
        check("alu wb_rd", wb_rd, 7);
        check("alu wb_pc", wb_pc, 64'h8000_ABCD);
        check("alu wb_regwrite", wb_regwrite, 1);

        // Sign/zero extension of a byte load
        dc_load("lb", 3'd0, 64'h1003, 64'h80, 64'hFFFF_FFFF_FFFF_FF80);
        dc_load("lbu", 3'd4, 64'h1003, 64'h80, 64'h80);
        dc_load("lh", 3'd1, 64'h1002, 64'h8001, 64'hFFFF_FFFF_FFFF_8001);
        dc_load("lwu", 3'd6, 64'h1004, 64'h8000_0000, 64'h8000_0000);

        // Misaligned word load
        op(1, 0, 0, 3'd2, 64'h1002, 0);
        #1;
        check("mis dc_req_valid", dc_req_valid, 0);
        check("mis stall", stall, 0);
        step();
        idle_in();
        check("mis wb_valid", wb_valid, 1);
        check("mis wb_misalign", wb_misalign, 1);
        check("mis sb_empty", sb_empty, 1);

        // Store then exact-match load forwards without a load request
        dc_req_ready = 0;
        op(0, 1, 0, 3'd3, 64'h1000, 64'h1122_3344_5566_7788);
        #1;
        check("sd stall", stall, 0);
        step();
        check("sd wb_valid", wb_valid, 1);
        check("sd sb_empty", sb_empty, 0);
        op(1, 0, 0, 3'd3, 64'h1000, 0);
        #1;
        check("fwd stall", stall, 0);
        check("fwd only drain on port", dc_req_we, 1);
        step();
        check("fwd wb_ld_result", wb_ld_result, 64'h1122_3344_5566_7788);
        check("fwd wb_valid", wb_valid, 1);

        // Partial overlap: sw 0x1004 then ld 0x1000 waits for the drain
        op(0, 1, 0, 3'd2, 64'h1004, 64'hDEAD_BEEF);
        #1;
        check("sw stall", stall, 0);
        step();
        op(1, 0, 0, 3'd3, 64'h1000, 0);
        #1;
        check("ovl stall", stall, 1);
        check("ovl port is drain", dc_req_we, 1);
        dc_req_ready = 1;
        #1;
        n_drain = 0;
        got_ld = 0;
        for (int cyc = 0; cyc < 12 && !got_ld; cyc++) begin
            if (dc_req_valid && dc_req_we) begin
                check($sformatf("ovl drain%0d addr", n_drain), dc_addr, (n_drain == 0) ? 64'h1000 : 64'h1004);
                check($sformatf("ovl drain%0d stall", n_drain), stall, 1);
                n_drain++;
            end else if (dc_req_valid && !dc_req_we) begin
                got_ld = 1;
                check("ovl sb_empty at issue", sb_empty, 1);
                check("ovl ld addr", dc_addr, 64'h1000);
            end
            if (!got_ld) step();
        end
        check("ovl load issued", got_ld, 1);
        check("ovl drains", n_drain, 2);
        step();
        dc_rsp_valid = 1; dc_rdata = 64'h0123_4567_89AB_CDEF;
        step();
        dc_rsp_valid = 0;
        idle_in();
        check("ovl wb_ld_result", wb_ld_result, 64'h0123_4567_89AB_CDEF);

        // Five back-to-back stores with a stalled cache
        dc_req_ready = 0;
        for (int i = 0; i < 5; i++) begin
            op(0, 1, 0, 3'd3, 64'h2000 + 64'(8 * i), 64'(i));
            #1;
            check($sformatf("st%0d stall", i), stall, (i == 4) ? 1 : 0);
            if (i < 4) step();
        end
        check("full head addr", dc_addr, 64'h2000);
        dc_req_ready = 1;
        #1;
        check("full stall while draining", stall, 1);
        step();
        check("after drain stall", stall, 0);
        step();
        idle_in();
        check("st4 wb_valid", wb_valid, 1);
        done = 0;
        for (int cyc = 0; cyc < 10 && !done; cyc++) begin
            if (sb_empty) done = 1;
            else step();
        end
        check("sb drained", sb_empty, 1);

        // Flush while a load is outstanding
        op(1, 0, 0, 3'd3, 64'h3000, 0);
        #1;
        check("kill req_valid", dc_req_valid, 1);
        step();
        flush = 1;
        #1;
        check("kill flush stall", stall, 0);
        step();
        flush = 0;
        check("kill wb_valid", wb_valid, 0);
        op(0, 0, 0, 0, 64'h44, 0);
        #1;
        check("ld_kill holds instr", stall, 1);
        check("ld_kill no req", dc_req_valid, 0);
        step();
        check("ld_kill wb bubble", wb_valid, 0);
        dc_rsp_valid = 1; dc_rdata = 64'h55;
        #1;
        check("ld_kill rsp stall", stall, 1);
        step();
        dc_rsp_valid = 0;
        check("dropped rsp wb_valid", wb_valid, 0);
        check("idle again stall", stall, 0);
        step();
        idle_in();
        check("post-kill wb_result", wb_result, 64'h44);
        check("post-kill mem_to_reg", wb_mem_to_reg, 0);

        // Ecall waits for the store buffer to empty
        dc_req_ready = 0;
        op(0, 1, 0, 3'd3, 64'h4000, 64'h99);
        step();
        op(0, 0, 1, 0, 0, 0);
        #1;
        check("ecall stall", stall, 1);
        step();
        check("ecall wb bubble", wb_valid, 0);
        dc_req_ready = 1;
        #1;
        done = 0;
        for (int cyc = 0; cyc < 8 && !done; cyc++) begin
            if (!stall) done = 1;
            else step();
        end
        check("ecall released", done, 1);
        step();
        idle_in();
        check("ecall wb_ecall", wb_ecall, 1);
        check("ecall wb_valid", wb_valid, 1);

        // Reset mid-operation clears the store buffer
        dc_req_ready = 0;
        op(0, 1, 0, 3'd3, 64'h5000, 64'h1);
        step();
        idle_in();
        check("pre-reset sb_empty", sb_empty, 0);
        reset = 1;
        step();
        reset = 0;
        check("mid reset sb_empty", sb_empty, 1);
        check("mid reset wb_valid", wb_valid, 0);
        check("mid reset dc_req_valid", dc_req_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
